// File: rtl/prism_cfg_loader.sv
// prism_cfg_loader
//   Configuration sequencer for the PRISM debug port. It holds PRISM in
//   debug reset, streams (address, data) words from a valid/ready source
//   into the debug write port, and can read each word back to verify it.
//   It then releases debug reset and optionally enables the PRISM FSM.
//   While idle or in error, host debug accesses pass straight through.
//
// Ports
//   clk, rst                      clock, asynchronous active-high reset
//   start, abort, clear           control pulses
//   verify_en, auto_enable        load options, sampled with start
//   src_valid/addr/data/last      configuration word source
//   src_ready                     high only while waiting for a word
//   host_addr/wr/wdata            host debug access
//   host_rdata, host_stall        read data to host; high while loader busy
//   debug_addr/wr/wdata/rdata     PRISM debug port
//   debug_reset, fsm_enable       registered PRISM controls
//   busy, done, error             status
//   err_code, err_addr            01 mismatch, 10 overflow, 11 source timeout
module prism_cfg_loader #(
    parameter int unsigned RST_CYCLES  = 4,
    parameter int unsigned MAX_WORDS   = 64,
    parameter int unsigned TIMEOUT     = 255,
    parameter logic [31:0] VERIFY_MASK = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic        clear,
    input  logic        verify_en,
    input  logic        auto_enable,
    input  logic        src_valid,
    input  logic [5:0]  src_addr,
    input  logic [31:0] src_data,
    input  logic        src_last,
    output logic        src_ready,
    input  logic [5:0]  host_addr,
    input  logic        host_wr,
    input  logic [31:0] host_wdata,
    output logic [31:0] host_rdata,
    output logic        host_stall,
    output logic [5:0]  debug_addr,
    output logic        debug_wr,
    output logic [31:0] debug_wdata,
    input  logic [31:0] debug_rdata,
    output logic        debug_reset,
    output logic        fsm_enable,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [1:0]  err_code,
    output logic [5:0]  err_addr
);

    localparam int unsigned WCW = $clog2(MAX_WORDS) + 1;
    localparam int unsigned RCW = $clog2(RST_CYCLES) + 1;
    localparam int unsigned ICW = $clog2(TIMEOUT + 1) + 1;
    localparam logic [WCW-1:0] MAX_L = WCW'(MAX_WORDS);
    localparam logic [RCW-1:0] RST_L = RCW'(RST_CYCLES - 1);
    localparam logic [ICW-1:0] TO_L  = ICW'(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HALT,
        S_WAIT,
        S_WR,
        S_VFY,
        S_DONE,
        S_ERROR
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [RCW-1:0]  rst_cnt;
    logic [WCW-1:0]  word_cnt;
    logic [ICW-1:0]  idle_cnt;
    logic            verify_lat;
    logic            auto_lat;
    logic            debug_reset_reg;
    logic            fsm_enable_reg;
    logic [1:0]      err_code_reg;
    logic [5:0]      err_addr_reg;

    // Registered copy of the word being written; data, so no reset.
    logic [5:0]      word_addr;
    logic [31:0]     word_data;
    logic            word_last;

    logic            do_start;
    logic            do_accept;
    logic            do_idle_inc;
    logic            do_err;
    logic [1:0]      err_set;
    logic            do_done;
    logic            do_clear;
    logic            do_abort;
    logic            mismatch;

    assign busy       = (state != S_IDLE) && (state != S_ERROR);
    assign done       = (state == S_DONE);
    assign error      = (state == S_ERROR);
    assign host_stall = busy;
    assign host_rdata = debug_rdata;
    // A full word counter refuses the next word, so ready drops with it.
    assign src_ready  = (state == S_WAIT) && (word_cnt != MAX_L);
    assign mismatch   = |((debug_rdata ^ word_data) & VERIFY_MASK);

    assign debug_reset = debug_reset_reg;
    assign fsm_enable  = fsm_enable_reg;
    assign err_code    = err_code_reg;
    assign err_addr    = err_addr_reg;

    // Debug port mux: host owns the port whenever the loader is not busy.
    always_comb begin
        if (busy) begin
            debug_addr  = word_addr;
            debug_wr    = (state == S_WR);
            debug_wdata = word_data;
        end else begin
            debug_addr  = host_addr;
            debug_wr    = host_wr;
            debug_wdata = host_wdata;
        end
    end

    always_comb begin
        state_next  = state;
        do_start    = 1'b0;
        do_accept   = 1'b0;
        do_idle_inc = 1'b0;
        do_err      = 1'b0;
        err_set     = 2'b00;
        do_done     = 1'b0;
        do_clear    = 1'b0;
        do_abort    = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_next = S_HALT;
                    do_start   = 1'b1;
                end
            end
            S_HALT: begin
                if (rst_cnt == '0) begin
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (src_valid) begin
                    if (word_cnt == MAX_L) begin
                        state_next = S_ERROR;
                        do_err     = 1'b1;
                        err_set    = 2'b10;
                    end else begin
                        state_next = S_WR;
                        do_accept  = 1'b1;
                    end
                end else if ((TIMEOUT != 0) && (idle_cnt >= TO_L)) begin
                    // idle_cnt already holds TIMEOUT idle cycles; this one exceeds it.
                    state_next = S_ERROR;
                    do_err     = 1'b1;
                    err_set    = 2'b11;
                end else begin
                    do_idle_inc = 1'b1;
                end
            end
            S_WR: begin
                if (verify_lat) begin
                    state_next = S_VFY;
                end else if (word_last) begin
                    state_next = S_DONE;
                end else begin
                    state_next = S_WAIT;
                end
            end
            S_VFY: begin
                if (mismatch) begin
                    state_next = S_ERROR;
                    do_err     = 1'b1;
                    err_set    = 2'b01;
                end else if (word_last) begin
                    state_next = S_DONE;
                end else begin
                    state_next = S_WAIT;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
                do_done    = 1'b1;
            end
            S_ERROR: begin
                // A new load takes priority over clearing the error.
                if (start) begin
                    state_next = S_HALT;
                    do_start   = 1'b1;
                end else if (clear) begin
                    state_next = S_IDLE;
                    do_clear   = 1'b1;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
        // Abort overrides every other event while a load is in progress.
        if (abort && busy) begin
            state_next  = S_IDLE;
            do_accept   = 1'b0;
            do_idle_inc = 1'b0;
            do_err      = 1'b0;
            do_done     = 1'b0;
            do_abort    = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= S_IDLE;
            rst_cnt         <= '0;
            word_cnt        <= '0;
            idle_cnt        <= '0;
            verify_lat      <= 1'b0;
            auto_lat        <= 1'b0;
            debug_reset_reg <= 1'b0;
            fsm_enable_reg  <= 1'b0;
            err_code_reg    <= 2'b00;
            err_addr_reg    <= 6'd0;
        end else begin
            state <= state_next;
            if (do_start) begin
                rst_cnt         <= RST_L;
                word_cnt        <= '0;
                idle_cnt        <= '0;
                verify_lat      <= verify_en;
                auto_lat        <= auto_enable;
                debug_reset_reg <= 1'b1;
                fsm_enable_reg  <= 1'b0;
                err_code_reg    <= 2'b00;
            end
            if ((state == S_HALT) && (rst_cnt != '0)) begin
                rst_cnt <= rst_cnt - 1'b1;
            end
            if (do_accept) begin
                word_cnt <= word_cnt + 1'b1;
                idle_cnt <= '0;
            end
            if (do_idle_inc) begin
                idle_cnt <= idle_cnt + 1'b1;
            end
            if (do_err) begin
                err_code_reg <= err_set;
                err_addr_reg <= word_addr;
            end
            if (do_done) begin
                debug_reset_reg <= 1'b0;
                fsm_enable_reg  <= auto_lat;
            end
            if (do_abort) begin
                debug_reset_reg <= 1'b1;
                fsm_enable_reg  <= 1'b0;
            end
            if (do_clear) begin
                err_code_reg <= 2'b00;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_accept) begin
            word_addr <= src_addr;
            word_data <= src_data;
            word_last <= src_last;
        end
    end

endmodule

// File: tb/tb_prism_cfg_loader.sv
// Testbench for prism_cfg_loader: directed loads plus randomized tables,
// with a PRISM register-file model on the debug port and a table-level
// reference model of the expected load outcome.
module tb_prism_cfg_loader;

    localparam int RSTC = 4;
    localparam int MAXW = 4;
    localparam int TOUT = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        clear = 1'b0;
    logic        verify_en = 1'b0;
    logic        auto_enable = 1'b0;
    logic        src_valid = 1'b0;
    logic [5:0]  src_addr = 6'd0;
    logic [31:0] src_data = 32'd0;
    logic        src_last = 1'b0;
    logic        src_ready;
    logic [5:0]  host_addr = 6'd0;
    logic        host_wr = 1'b0;
    logic [31:0] host_wdata = 32'd0;
    logic [31:0] host_rdata;
    logic        host_stall;
    logic [5:0]  debug_addr;
    logic        debug_wr;
    logic [31:0] debug_wdata;
    logic [31:0] debug_rdata;
    logic        debug_reset;
    logic        fsm_enable;
    logic        busy;
    logic        done;
    logic        error;
    logic [1:0]  err_code;
    logic [5:0]  err_addr;

    prism_cfg_loader #(
        .RST_CYCLES (RSTC),
        .MAX_WORDS  (MAXW),
        .TIMEOUT    (TOUT),
        .VERIFY_MASK(32'hFFFF_FFFF)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .clear      (clear),
        .verify_en  (verify_en),
        .auto_enable(auto_enable),
        .src_valid  (src_valid),
        .src_addr   (src_addr),
        .src_data   (src_data),
        .src_last   (src_last),
        .src_ready  (src_ready),
        .host_addr  (host_addr),
        .host_wr    (host_wr),
        .host_wdata (host_wdata),
        .host_rdata (host_rdata),
        .host_stall (host_stall),
        .debug_addr (debug_addr),
        .debug_wr   (debug_wr),
        .debug_wdata(debug_wdata),
        .debug_rdata(debug_rdata),
        .debug_reset(debug_reset),
        .fsm_enable (fsm_enable),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .err_code   (err_code),
        .err_addr   (err_addr)
    );

    always #5 clk = ~clk;

    // PRISM register file; optionally corrupts readback at one address.
    logic [31:0] mem [64] = '{default: 32'h0};
    logic        corrupt_on = 1'b0;
    logic [5:0]  corrupt_addr = 6'd0;
    always @(posedge clk) if (debug_wr) mem[debug_addr] <= debug_wdata;
    assign debug_rdata = mem[debug_addr] ^ ((corrupt_on && (debug_addr == corrupt_addr)) ? 32'h1 : 32'h0);

    int passes = 0;
    int fails = 0;
    int total = 0;
    int cyc = 0;

    logic [5:0]  tbl_a [8];
    logic [31:0] tbl_d [8];
    logic        tbl_l [8];
    int          n = 0;
    int          idx = 0;
    logic        src_en = 1'b0;
    logic        bubbles_on = 1'b0;
    logic        bubble = 1'b0;

    logic [5:0]  log_a [16];
    logic [31:0] log_d [16];
    int          log_t [16];
    int          wcnt = 0;
    int          done_cnt = 0;
    int          pre_cnt = 0;
    int          rdy_cnt = 0;

    logic [1:0]  exp_code;
    logic [5:0]  exp_ea;
    int          exp_w;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_src();
        bubble = bubbles_on && !bubble && ($urandom_range(0, 2) == 0);
        src_valid = src_en && (idx < n) && !bubble;
        if (idx < n) begin
            src_addr = tbl_a[idx];
            src_data = tbl_d[idx];
            src_last = tbl_l[idx];
        end else begin
            src_addr = 6'd0;
            src_data = 32'd0;
            src_last = 1'b0;
        end
    endtask

    // Observe one cycle, let the clock edge happen, then drive the source.
    task automatic step();
        logic take;
        #1;
        if (debug_wr) begin
            if (wcnt < 16) begin
                log_a[wcnt] = debug_addr;
                log_d[wcnt] = debug_wdata;
                log_t[wcnt] = cyc;
            end
            wcnt++;
        end
        if (done) done_cnt++;
        if (busy && debug_reset && (wcnt == 0)) pre_cnt++;
        if (src_ready) rdy_cnt++;
        take = src_valid && src_ready;
        @(posedge clk);
        #1;
        cyc++;
        if (take) idx++;
        drive_src();
    endtask

    task automatic begin_load(input logic vfy, input logic aut);
        verify_en = vfy;
        auto_enable = aut;
        wcnt = 0;
        done_cnt = 0;
        pre_cnt = 0;
        rdy_cnt = 0;
        idx = 0;
        src_en = 1'b1;
        drive_src();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_end(input string tag);
        int g;
        g = 0;
        while ((done_cnt == 0) && !error && (g < 300)) begin
            step();
            g++;
        end
        check({tag, "_bound"}, 64'(g < 300), 64'd1);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    // Outcome of a load, derived from the table alone.
    task automatic model(input logic vfy);
        exp_w = 0;
        exp_code = 2'b11;
        exp_ea = 6'd0;
        for (int i = 0; i < n; i++) begin
            if (i == MAXW) begin
                exp_code = 2'b10;
                exp_ea = tbl_a[i-1];
                break;
            end
            exp_w++;
            if (vfy && corrupt_on && (tbl_a[i] == corrupt_addr)) begin
                exp_code = 2'b01;
                exp_ea = tbl_a[i];
                break;
            end
            if (tbl_l[i]) begin
                exp_code = 2'b00;
                break;
            end
        end
        if ((exp_code == 2'b11) && (exp_w > 0)) exp_ea = tbl_a[exp_w-1];
    endtask

    task automatic load_fixed(input logic last_on_third);
        n = 3;
        for (int i = 0; i < 3; i++) begin
            tbl_a[i] = 6'(i * 4);
            tbl_d[i] = $urandom;
            tbl_l[i] = last_on_third && (i == 2);
        end
    endtask

    initial begin
        logic [31:0] hw;
        logic        vfy;
        logic        aut;
        int          lp;
        int          g;

        drive_src();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_error", 64'(error), 64'd0);
        check("rst_err_code", 64'(err_code), 64'd0);
        check("rst_err_addr", 64'(err_addr), 64'd0);
        check("rst_debug_reset", 64'(debug_reset), 64'd0);
        check("rst_fsm_enable", 64'(fsm_enable), 64'd0);
        check("rst_src_ready", 64'(src_ready), 64'd0);
        check("rst_host_stall", 64'(host_stall), 64'd0);
        check("rst_host_rdata", 64'(host_rdata), 64'd0);

        // Three-word load, no verify, host write attempted mid-load.
        load_fixed(1'b1);
        begin_load(1'b0, 1'b1);
        host_addr = 6'h3F;
        host_wdata = 32'hDEAD_BEEF;
        host_wr = 1'b1;
        #1;
        check("t1_host_stall", 64'(host_stall), 64'd1);
        check("t1_src_ready_halt", 64'(src_ready), 64'd0);
        wait_end("t1");
        host_wr = 1'b0;
        host_addr = 6'd0;
        check("t1_wcnt", 64'(wcnt), 64'd3);
        for (int i = 0; i < 3; i++) check("t1_write", {26'd0, log_a[i], log_d[i]}, {26'd0, tbl_a[i], tbl_d[i]});
        check("t1_gap01", 64'(log_t[1] - log_t[0]), 64'd2);
        check("t1_gap12", 64'(log_t[2] - log_t[1]), 64'd2);
        check("t1_halt_len", 64'(pre_cnt >= RSTC), 64'd1);
        check("t1_done_cnt", 64'(done_cnt), 64'd1);
        check("t1_debug_reset", 64'(debug_reset), 64'd0);
        check("t1_fsm_enable", 64'(fsm_enable), 64'd1);
        check("t1_busy", 64'(busy), 64'd0);
        check("t1_host_dropped", 64'(mem[6'h3F]), 64'd0);

        // Host write while idle passes straight through.
        hw = $urandom;
        host_addr = 6'h10;
        host_wdata = hw;
        host_wr = 1'b1;
        #1;
        check("host_idle_wr", 64'(debug_wr), 64'd1);
        check("host_idle_addr", 64'(debug_addr), 64'h10);
        check("host_idle_wdata", 64'(debug_wdata), 64'(hw));
        step();
        host_wr = 1'b0;
        #1;
        check("host_idle_rdata", 64'(host_rdata), 64'(hw));
        check("host_idle_fsm_enable", 64'(fsm_enable), 64'd1);
        check("host_idle_debug_reset", 64'(debug_reset), 64'd0);
        host_addr = 6'd0;

        // Verify with a corrupted readback at address 0x04.
        load_fixed(1'b1);
        corrupt_on = 1'b1;
        corrupt_addr = 6'h04;
        begin_load(1'b1, 1'b1);
        wait_end("t2");
        check("t2_error", 64'(error), 64'd1);
        check("t2_err_code", 64'(err_code), 64'd1);
        check("t2_err_addr", 64'(err_addr), 64'h04);
        check("t2_debug_reset", 64'(debug_reset), 64'd1);
        check("t2_fsm_enable", 64'(fsm_enable), 64'd0);
        check("t2_src_ready", 64'(src_ready), 64'd0);
        check("t2_wcnt", 64'(wcnt), 64'd2);
        check("t2_gap_verify", 64'(log_t[1] - log_t[0]), 64'd3);
        check("t2_no_done", 64'(done_cnt), 64'd0);
        corrupt_on = 1'b0;
        do_clear();
        check("t2_clear_error", 64'(error), 64'd0);
        check("t2_clear_code", 64'(err_code), 64'd0);
        check("t2_clear_busy", 64'(busy), 64'd0);

        // Overflow: six words, no last, MAX_WORDS of four.
        n = 6;
        for (int i = 0; i < 6; i++) begin
            tbl_a[i] = 6'(32 + i);
            tbl_d[i] = $urandom;
            tbl_l[i] = 1'b0;
        end
        begin_load(1'b0, 1'b0);
        wait_end("t3");
        check("t3_err_code", 64'(err_code), 64'd2);
        check("t3_err_addr", 64'(err_addr), 64'h23);
        check("t3_wcnt", 64'(wcnt), 64'd4);
        do_clear();

        // Source timeout: empty table.
        n = 0;
        begin_load(1'b0, 1'b0);
        wait_end("t4");
        check("t4_err_code", 64'(err_code), 64'd3);
        check("t4_wait_cycles", 64'(rdy_cnt), 64'(TOUT + 1));
        check("t4_wcnt", 64'(wcnt), 64'd0);
        do_clear();

        // Randomized tables with source bubbles.
        bubbles_on = 1'b1;
        for (int it = 0; it < 10; it++) begin
            n = $urandom_range(1, 6);
            lp = $urandom_range(0, 6);
            for (int i = 0; i < n; i++) begin
                tbl_a[i] = 6'($urandom);
                tbl_d[i] = $urandom;
                tbl_l[i] = (i == lp);
            end
            vfy = 1'($urandom);
            aut = 1'($urandom);
            corrupt_on = 1'($urandom);
            corrupt_addr = tbl_a[$urandom_range(0, n - 1)];
            model(vfy);
            begin_load(vfy, aut);
            wait_end("rnd");
            check("rnd_code", 64'(error ? err_code : 2'b00), 64'(exp_code));
            check("rnd_done", 64'(done_cnt), 64'(exp_code == 2'b00));
            check("rnd_wcnt", 64'(wcnt), 64'(exp_w));
            for (int i = 0; i < exp_w; i++) check("rnd_write", {26'd0, log_a[i], log_d[i]}, {26'd0, tbl_a[i], tbl_d[i]});
            if (exp_code == 2'b00) begin
                check("rnd_fsm_enable", 64'(fsm_enable), 64'(aut));
                check("rnd_debug_reset", 64'(debug_reset), 64'd0);
            end else begin
                check("rnd_err_addr", 64'(err_addr), 64'(exp_ea));
                check("rnd_err_fsm_enable", 64'(fsm_enable), 64'd0);
                check("rnd_err_debug_reset", 64'(debug_reset), 64'd1);
                do_clear();
            end
            corrupt_on = 1'b0;
        end
        bubbles_on = 1'b0;
        bubble = 1'b0;

        // Abort during a write.
        load_fixed(1'b1);
        begin_load(1'b0, 1'b1);
        g = 0;
        while (!debug_wr && (g < 50)) begin
            step();
            g++;
        end
        check("abort_reach_wr", 64'(debug_wr), 64'd1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_debug_reset", 64'(debug_reset), 64'd1);
        check("abort_fsm_enable", 64'(fsm_enable), 64'd0);
        check("abort_error", 64'(error), 64'd0);
        repeat (6) step();
        check("abort_no_done", 64'(done_cnt), 64'd0);
        check("abort_stays_idle", 64'(busy), 64'd0);

        // Asynchronous reset during verify.
        load_fixed(1'b1);
        begin_load(1'b1, 1'b1);
        g = 0;
        while (!debug_wr && (g < 50)) begin
            step();
            g++;
        end
        check("rst_reach_wr", 64'(debug_wr), 64'd1);
        step();
        check("vfy_no_wr", 64'(debug_wr), 64'd0);
        check("vfy_addr", 64'(debug_addr), 64'(tbl_a[0]));
        #2;
        rst = 1'b1;
        #1;
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_debug_reset", 64'(debug_reset), 64'd0);
        check("arst_fsm_enable", 64'(fsm_enable), 64'd0);
        check("arst_err_code", 64'(err_code), 64'd0);
        check("arst_err_addr", 64'(err_addr), 64'd0);
        check("arst_done", 64'(done), 64'd0);
        check("arst_error", 64'(error), 64'd0);
        check("arst_src_ready", 64'(src_ready), 64'd0);
        check("arst_debug_wr", 64'(debug_wr), 64'd0);
        #1;
        rst = 1'b0;
        src_en = 1'b0;
        done_cnt = 0;
        repeat (6) step();
        check("arst_no_done", 64'(done_cnt), 64'd0);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
